imem_fetch: RTL and testbench

IMEM_FETCH -- requirements
Module: imem_fetch

---
 rtl/imem_fetch_pkg.sv | 19 +
 rtl/imem_fetch_if.sv | 26 ++
 rtl/imem_array.sv | 28 ++
 rtl/imem_fetch.sv | 111 +++++++++++
 tb/tb_imem_fetch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package imem_fetch_pkg;

   localparam int INSTR_W_DEFAULT = 16;
   localparam int ADDR_W          = 8;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   // Counter preload so that the completion cycle lands WAIT_CYCLES cycles after ISSUE.
   function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
      return CNT_W'(wait_cycles - 1);
   endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch-stage bus: program counter / flush side, decode side and program-load port.
interface imem_fetch_if
   import imem_fetch_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEFAULT
);
   logic [ADDR_W-1:0]  pc;
   logic               flush;
   logic               stall_d;
   logic               prog_we;
   logic [ADDR_W-1:0]  prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic               StallF;

   modport master (
      output pc, flush, stall_d, prog_we, prog_addr, prog_data,
      input  instr, instr_valid, StallF
   );

   modport slave (
      input  pc, flush, stall_d, prog_we, prog_addr, prog_data,
      output instr, instr_valid, StallF
   );
endinterface

// File: rtl/imem_array.sv
// Instruction store: one write port and one registered, read-first read port.
module imem_array
   import imem_fetch_pkg::*;
#(
   parameter int INSTR_W = INSTR_W_DEFAULT,
   parameter int DEPTH   = 256
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               rd_en,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [INSTR_W-1:0] rd_data
);
   logic [INSTR_W-1:0] mem [DEPTH];

   // Non-blocking update makes a same-edge read of the written word return the old data.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch stage: fixed-latency memory access with decode back-pressure,
// branch flush and a program-load write port into the instruction store.
module imem_fetch
   import imem_fetch_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int INSTR_W     = INSTR_W_DEFAULT,
   parameter int DEPTH       = 256
) (
   input  logic        clk,
   input  logic        reset,
   imem_fetch_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

   fetch_state_t       state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   logic               instr_valid_reg, instr_valid_next;
   logic               loaded_reg, loaded_next;
   logic               complete;
   logic               rd_en;
   logic               stall_f;
   logic [INSTR_W-1:0] rd_data;

   assign complete = (state_reg == WAIT) && (cnt_reg == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= ISSUE;
         cnt_reg         <= '0;
         addr_reg        <= '0;
         instr_valid_reg <= 1'b0;
         loaded_reg      <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         addr_reg        <= addr_next;
         instr_valid_reg <= instr_valid_next;
         loaded_reg      <= loaded_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      addr_next        = addr_reg;
      instr_valid_next = 1'b0;
      loaded_next      = loaded_reg;
      if (bus.flush) begin
         state_next = ISSUE;
      end else begin
         case (state_reg)
            ISSUE: begin
               addr_next  = bus.pc;
               cnt_next   = CNT_LOAD;
               state_next = WAIT;
            end
            WAIT: begin
               if (cnt_reg != '0) begin
                  cnt_next = cnt_reg - 1'b1;
               end else begin
                  instr_valid_next = 1'b1;
                  loaded_next      = 1'b1;
                  state_next       = bus.stall_d ? HOLD : ISSUE;
               end
            end
            HOLD: begin
               instr_valid_next = instr_valid_reg;
               if (!bus.stall_d) begin
                  state_next = ISSUE;
               end
            end
            default: state_next = ISSUE;
         endcase
      end
   end

   // The memory read is launched on the completion edge; a flush on that cycle suppresses it.
   always_comb begin
      stall_f = 1'b1;
      rd_en   = 1'b0;
      if (!reset) begin
         stall_f = 1'b1;
      end else if (bus.flush) begin
         stall_f = 1'b0;
      end else if (complete) begin
         stall_f = 1'b0;
         rd_en   = 1'b1;
      end
   end

   imem_array #(
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH)
   ) u_array (
      .clk     (clk),
      .we      (bus.prog_we),
      .wr_addr (bus.prog_addr),
      .wr_data (bus.prog_data),
      .rd_en   (rd_en),
      .rd_addr (addr_reg),
      .rd_data (rd_data)
   );

   // The array's read register carries the word; loaded_reg gives it a reset value of zero.
   assign bus.instr       = loaded_reg ? rd_data : '0;
   assign bus.instr_valid = instr_valid_reg;
   assign bus.StallF      = stall_f;

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch with a transaction-level reference model checked every cycle.
module tb_imem_fetch;
   localparam int W = 2;

   logic  clk = 1'b0;
   logic  reset = 1'b0;
   int    vectors = 0;
   int    miscompares = 0;
   int    cy = 0;
   string scen = "init";

   always #5 clk = ~clk;

   imem_fetch_if #(.INSTR_W(16)) bus ();

   imem_fetch #(
      .WAIT_CYCLES (W),
      .INSTR_W     (16),
      .DEPTH       (256)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // Reference model: a fetch issued in cycle t completes in cycle t+W and is visible at t+W+1.
   logic [15:0] model_mem [256];
   bit          m_issue = 1'b1;
   bit          m_busy  = 1'b0;
   bit          m_hold  = 1'b0;
   bit          m_valid = 1'b0;
   int          m_age   = 0;
   logic [7:0]  m_addr  = 8'h00;
   logic [15:0] m_instr = 16'h0000;

   initial begin
      bit nv;
      bit es;
      forever begin
         @(negedge clk);
         if (!reset) begin
            m_issue = 1'b1; m_busy = 1'b0; m_hold = 1'b0;
            m_valid = 1'b0; m_instr = 16'h0000;
         end
         if (!reset)                          es = 1'b1;
         else if (bus.flush)                  es = 1'b0;
         else if (m_busy && m_age == W)       es = 1'b0;
         else                                 es = 1'b1;
         chk("model StallF", 32'(bus.StallF), 32'(es));
         chk("model instr_valid", 32'(bus.instr_valid), 32'(m_valid));
         chk("model instr", 32'(bus.instr), 32'(m_instr));
         if (bus.instr_valid)
            $display("word %h valid at %0t (%s c%0d)", bus.instr, $time, scen, cy);
         if (reset) begin
            nv = 1'b0;
            if (bus.flush) begin
               m_issue = 1'b1; m_busy = 1'b0; m_hold = 1'b0;
            end else if (m_issue) begin
               m_addr = bus.pc; m_age = 1; m_busy = 1'b1; m_issue = 1'b0;
            end else if (m_busy) begin
               if (m_age == W) begin
                  m_instr = model_mem[m_addr];
                  nv      = 1'b1;
                  m_busy  = 1'b0;
                  m_hold  = bus.stall_d;
                  m_issue = !bus.stall_d;
               end else begin
                  m_age++;
               end
            end else if (m_hold) begin
               nv = 1'b1;
               if (!bus.stall_d) begin
                  m_hold = 1'b0; m_issue = 1'b1;
               end
            end
            m_valid = nv;
         end
         // Writes land after the completion read, so a same-edge read sees the old word.
         if (bus.prog_we) model_mem[bus.prog_addr] = bus.prog_data;
      end
   end

   task automatic tick(input int es, input int ev, input int ei);
      @(negedge clk);
      chk($sformatf("%s c%0d StallF", scen, cy), 32'(bus.StallF), 32'(es));
      chk($sformatf("%s c%0d instr_valid", scen, cy), 32'(bus.instr_valid), 32'(ev));
      chk($sformatf("%s c%0d instr", scen, cy), 32'(bus.instr), 32'(ei));
      @(posedge clk);
      #1;
      cy++;
   endtask

   task automatic load(input logic [7:0] a, input logic [15:0] d);
      bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
      @(posedge clk);
      #1;
      bus.prog_we = 1'b0;
   endtask

   task automatic start(input string name, input logic [7:0] first_pc);
      scen = name;
      reset = 1'b0;
      bus.flush = 1'b0; bus.stall_d = 1'b0; bus.prog_we = 1'b0; bus.pc = first_pc;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      cy = 0;
   endtask

   initial begin
      bus.pc = 8'h00; bus.flush = 1'b0; bus.stall_d = 1'b0;
      bus.prog_we = 1'b0; bus.prog_addr = 8'h00; bus.prog_data = 16'h0000;
      @(posedge clk); #1;
      load(8'h00, 16'h1234);
      load(8'h01, 16'hABCD);
      load(8'h40, 16'h4040);
      load(8'hFF, 16'hF00F);

      // Back-to-back fetches of 0x00 and 0x01.
      start("b2b", 8'h00);
      tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);
      bus.pc = 8'h01;
      tick(1, 1, 16'h1234); tick(1, 0, 16'h1234); tick(0, 0, 16'h1234);
      bus.pc = 8'h02;
      tick(1, 1, 16'hABCD);

      // Decode stall across the completion: word held, then next issue.
      start("hold", 8'h00);
      tick(1, 0, 0); tick(1, 0, 0);
      bus.stall_d = 1'b1;
      tick(0, 0, 0);
      bus.pc = 8'h01;
      tick(1, 1, 16'h1234); tick(1, 1, 16'h1234);
      bus.stall_d = 1'b0;
      tick(1, 1, 16'h1234); tick(1, 1, 16'h1234);
      tick(1, 0, 16'h1234); tick(0, 0, 16'h1234); tick(1, 1, 16'hABCD);

      // Flush mid-fetch redirects to 0x40.
      start("flush", 8'h00);
      tick(1, 0, 0);
      bus.flush = 1'b1; bus.pc = 8'h40;
      tick(0, 0, 0);
      bus.flush = 1'b0;
      tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(1, 1, 16'h4040);

      // Fetch of 0xFF, then a flush while holding.
      start("top", 8'hFF);
      tick(1, 0, 0); tick(1, 0, 0);
      bus.stall_d = 1'b1;
      tick(0, 0, 0);
      tick(1, 1, 16'hF00F);
      bus.flush = 1'b1;
      tick(0, 1, 16'hF00F);
      bus.flush = 1'b0; bus.stall_d = 1'b0; bus.pc = 8'h01;
      tick(1, 0, 16'hF00F); tick(1, 0, 16'hF00F); tick(0, 0, 16'hF00F); tick(1, 1, 16'hABCD);

      // Write on the completion edge of the same address returns the old word.
      start("rbw", 8'h00);
      tick(1, 0, 0); tick(1, 0, 0);
      bus.prog_we = 1'b1; bus.prog_addr = 8'h00; bus.prog_data = 16'h5555;
      tick(0, 0, 0);
      bus.prog_we = 1'b0;
      tick(1, 1, 16'h1234); tick(1, 0, 16'h1234); tick(0, 0, 16'h1234); tick(1, 1, 16'h5555);

      // Reset dropped mid-fetch clears outputs at once; no stale pulse after release.
      scen = "rst";
      reset = 1'b0;
      #1;
      chk("rst async instr", 32'(bus.instr), 32'h0);
      chk("rst async instr_valid", 32'(bus.instr_valid), 32'h0);
      chk("rst async StallF", 32'(bus.StallF), 32'h1);
      tick(1, 0, 0); tick(1, 0, 0);
      bus.pc = 8'h01;
      reset = 1'b1;
      cy = 0;
      tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(1, 1, 16'hABCD);
      tick(1, 0, 16'hABCD);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      miscompares++;
      $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
